// File: rtl/zlib_bs_sched.sv
// Frame sequencer for the zlib bitstream writer.
// Sequences start/header, forwards LZ77 tokens one stage late, waits for done.
module zlib_bs_sched #(
    parameter int HDR_CYC = 3,
    parameter int DONE_TO = 16,
    parameter int CNT_WD  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frm_start_i,
    input  logic              tok_val_i,
    output logic              tok_rdy_o,
    input  logic              tok_flg_lit_i,
    input  logic [7:0]        tok_lit_i,
    input  logic [6:0]        tok_len_i,
    input  logic [6:0]        tok_dis_i,
    input  logic              tok_lst_i,
    output logic              bs_start_o,
    output logic              bs_val_o,
    output logic              bs_flg_lit_o,
    output logic [7:0]        bs_lit_o,
    output logic [6:0]        bs_len_o,
    output logic [6:0]        bs_dis_o,
    output logic              bs_lst_o,
    input  logic              bs_done_i,
    output logic              busy_o,
    output logic              frm_done_o,
    output logic              err_o,
    output logic [CNT_WD-1:0] tok_cnt_o
);

    localparam int HW = (HDR_CYC > 1) ? $clog2(HDR_CYC) : 1;
    localparam int TW = $clog2(DONE_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HDR,
        S_STRM,
        S_TAIL,
        S_DONE
    } state_t;

    state_t        state;
    logic [HW-1:0] hdr_cnt;
    logic [TW-1:0] tmr;
    logic          acc;

    assign tok_rdy_o = (state == S_STRM);
    assign acc       = tok_val_i & tok_rdy_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            hdr_cnt      <= '0;
            tmr          <= '0;
            bs_start_o   <= 1'b0;
            bs_val_o     <= 1'b0;
            bs_flg_lit_o <= 1'b0;
            bs_lit_o     <= '0;
            bs_len_o     <= '0;
            bs_dis_o     <= '0;
            bs_lst_o     <= 1'b0;
            busy_o       <= 1'b0;
            frm_done_o   <= 1'b0;
            err_o        <= 1'b0;
            tok_cnt_o    <= '0;
        end else begin
            bs_start_o <= 1'b0;
            frm_done_o <= 1'b0;
            bs_val_o   <= acc;
            bs_lst_o   <= acc & tok_lst_i;
            if (acc) begin
                bs_flg_lit_o <= tok_flg_lit_i;
                bs_lit_o     <= tok_lit_i;
                bs_len_o     <= tok_len_i;
                bs_dis_o     <= tok_dis_i;
            end
            // saturate rather than wrap on very long frames
            if (acc && (tok_cnt_o != '1))
                tok_cnt_o <= tok_cnt_o + 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (frm_start_i) begin
                        state      <= S_START;
                        bs_start_o <= 1'b1;
                        busy_o     <= 1'b1;
                        err_o      <= 1'b0;
                        tok_cnt_o  <= '0;
                    end
                end
                S_START: begin
                    state   <= S_HDR;
                    hdr_cnt <= '0;
                end
                S_HDR: begin
                    if (hdr_cnt == HW'(HDR_CYC - 1))
                        state <= S_STRM;
                    else
                        hdr_cnt <= hdr_cnt + 1'b1;
                end
                S_STRM: begin
                    if (acc && tok_lst_i) begin
                        state <= S_TAIL;
                        tmr   <= '0;
                    end
                end
                S_TAIL: begin
                    // done beats a coincident timeout
                    if (bs_done_i) begin
                        state      <= S_DONE;
                        frm_done_o <= 1'b1;
                    end else if (tmr == TW'(DONE_TO)) begin
                        state      <= S_DONE;
                        frm_done_o <= 1'b1;
                        err_o      <= 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zlib_bs_sched.sv
// Directed bench for zlib_bs_sched.
// Scoreboard of forwarded tokens; counter width reduced to reach saturation.
module tb_zlib_bs_sched;

    localparam int HDR_CYC = 3;
    localparam int DONE_TO = 16;
    localparam int CNT_WD  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              frm_start_i;
    logic              tok_val_i;
    logic              tok_rdy_o;
    logic              tok_flg_lit_i;
    logic [7:0]        tok_lit_i;
    logic [6:0]        tok_len_i;
    logic [6:0]        tok_dis_i;
    logic              tok_lst_i;
    logic              bs_start_o;
    logic              bs_val_o;
    logic              bs_flg_lit_o;
    logic [7:0]        bs_lit_o;
    logic [6:0]        bs_len_o;
    logic [6:0]        bs_dis_o;
    logic              bs_lst_o;
    logic              bs_done_i;
    logic              busy_o;
    logic              frm_done_o;
    logic              err_o;
    logic [CNT_WD-1:0] tok_cnt_o;

    zlib_bs_sched #(
        .HDR_CYC(HDR_CYC),
        .DONE_TO(DONE_TO),
        .CNT_WD (CNT_WD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frm_start_i  (frm_start_i),
        .tok_val_i    (tok_val_i),
        .tok_rdy_o    (tok_rdy_o),
        .tok_flg_lit_i(tok_flg_lit_i),
        .tok_lit_i    (tok_lit_i),
        .tok_len_i    (tok_len_i),
        .tok_dis_i    (tok_dis_i),
        .tok_lst_i    (tok_lst_i),
        .bs_start_o   (bs_start_o),
        .bs_val_o     (bs_val_o),
        .bs_flg_lit_o (bs_flg_lit_o),
        .bs_lit_o     (bs_lit_o),
        .bs_len_o     (bs_len_o),
        .bs_dis_o     (bs_dis_o),
        .bs_lst_o     (bs_lst_o),
        .bs_done_i    (bs_done_i),
        .busy_o       (busy_o),
        .frm_done_o   (frm_done_o),
        .err_o        (err_o),
        .tok_cnt_o    (tok_cnt_o)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;
    int nval = 0;
    int ndone = 0;
    logic [23:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] lit(input logic [7:0] b, input logic l);
        return {1'b1, b, 7'd0, 7'd0, l};
    endfunction

    function automatic logic [23:0] pair(input logic [6:0] ln,
                                         input logic [6:0] ds, input logic l);
        return {1'b0, 8'd0, ln, ds, l};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bs_val_o) begin
                nval++;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0)
                    chk("bs_tok", {bs_flg_lit_o, bs_lit_o, bs_len_o,
                                   bs_dis_o, bs_lst_o}, sb.pop_front());
            end else begin
                chk("lst_wo_val", bs_lst_o, 0);
            end
            if (frm_done_o)
                ndone++;
        end
    end

    task automatic set_tok(input logic [23:0] t);
        {tok_flg_lit_i, tok_lit_i, tok_len_i, tok_dis_i, tok_lst_i} = t;
    endtask

    // pulse start at t0, check start pulse and header hold-off up to t5
    task automatic do_start();
        frm_start_i = 1'b1;
        @(negedge clk);
        frm_start_i = 1'b0;
        chk("start_t1", bs_start_o, 1);
        chk("busy_t1", busy_o, 1);
        chk("cnt_clr", tok_cnt_o, 0);
        chk("err_clr", err_o, 0);
        chk("rdy_t1", tok_rdy_o, 0);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk("start_pulse", bs_start_o, 0);
            chk("rdy_hdr", tok_rdy_o, 32'(i == 5));
            chk("val_hdr", bs_val_o, 0);
        end
    endtask

    task automatic send(input logic [23:0] t, input int gap);
        int k;
        tok_val_i = 1'b0;
        repeat (gap) @(negedge clk);
        set_tok(t);
        tok_val_i = 1'b1;
        k = 0;
        while (!tok_rdy_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            chk("rdy_timeout", tok_rdy_o, 1);
        end else begin
            sb.push_back(t);
            @(negedge clk);
        end
        tok_val_i = 1'b0;
    endtask

    // called in first TAIL cycle; writer done d cycles later
    task automatic finish(input int d);
        int n0;
        n0 = ndone;
        chk("rdy_drop", tok_rdy_o, 0);
        chk("lst_tail", bs_lst_o, 1);
        repeat (d - 1) @(negedge clk);
        bs_done_i = 1'b1;
        @(negedge clk);
        bs_done_i = 1'b0;
        chk("frm_done", frm_done_o, 1);
        @(negedge clk);
        chk("frm_done_1cyc", frm_done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("done_once", ndone - n0, 1);
    endtask

    initial begin
        int k;
        int n;
        rst = 1'b1;
        frm_start_i = 1'b0;
        tok_val_i = 1'b0;
        bs_done_i = 1'b0;
        set_tok('0);
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_rdy", tok_rdy_o, 0);
        chk("rst_start", bs_start_o, 0);
        chk("rst_val", bs_val_o, 0);
        chk("rst_done", frm_done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cnt", tok_cnt_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: three literals, writer done 4 cycles into TAIL
        do_start();
        send(lit(8'h41, 0), 0);
        send(lit(8'h42, 0), 0);
        send(lit(8'h43, 1), 0);
        finish(4);
        chk("t1_cnt", tok_cnt_o, 3);
        chk("t1_err", err_o, 0);
        repeat (2) @(negedge clk);

        // 2: token valid held from t0
        nval = 0;
        set_tok(lit(8'h10, 0));
        tok_val_i = 1'b1;
        do_start();
        send(lit(8'h10, 0), 0);
        send(pair(7'd5, 7'd12, 0), 0);
        send(lit(8'h11, 1), 0);
        finish(2);
        chk("t2_nval", nval, 3);
        chk("t2_cnt", tok_cnt_o, 3);

        // 3: mixed tokens with random gaps
        nval = 0;
        do_start();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                send(lit(8'(8'h60 + i), 1'(i == 7)), $urandom_range(0, 3));
            else
                send(pair(7'd5, 7'd12, 1'(i == 7)), $urandom_range(0, 3));
        end
        finish(1);
        chk("t3_nval", nval, 8);
        chk("t3_cnt_eq_val", tok_cnt_o, 32'(nval));

        // counter saturation
        nval = 0;
        do_start();
        for (int i = 0; i < 20; i++)
            send(lit(8'(i), 1'(i == 19)), 0);
        finish(2);
        chk("sat_nval", nval, 20);
        chk("sat_cnt", tok_cnt_o, 15);

        // 4: writer never completes
        do_start();
        send(pair(7'd9, 7'd3, 1), 0);
        chk("t4_lst", bs_lst_o, 1);
        k = 0;
        while (!frm_done_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_to_cyc", k, DONE_TO + 1);
        chk("t4_err", err_o, 1);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", err_o, 1);
        chk("t4_idle", busy_o, 0);

        // 5: stray starts and stray done ignored
        do_start();
        send(lit(8'h70, 0), 0);
        frm_start_i = 1'b1;
        bs_done_i = 1'b1;
        @(negedge clk);
        frm_start_i = 1'b0;
        bs_done_i = 1'b0;
        chk("t5_strm_start", bs_start_o, 0);
        chk("t5_strm_busy", busy_o, 1);
        chk("t5_strm_rdy", tok_rdy_o, 1);
        send(lit(8'h71, 1), 0);
        repeat (2) @(negedge clk);
        bs_done_i = 1'b1;
        @(negedge clk);
        bs_done_i = 1'b0;
        chk("t5_done", frm_done_o, 1);
        chk("t5_cnt", tok_cnt_o, 2);
        frm_start_i = 1'b1;
        @(negedge clk);
        chk("t5_done_start", bs_start_o, 0);
        chk("t5_done_busy", busy_o, 0);
        do_start();
        send(lit(8'h72, 1), 0);
        finish(1);
        chk("t5_cnt2", tok_cnt_o, 1);

        // 6: reset in HDR, then in STRM
        frm_start_i = 1'b1;
        @(negedge clk);
        frm_start_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("r1_busy", busy_o, 0);
        chk("r1_start", bs_start_o, 0);
        chk("r1_rdy", tok_rdy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        do_start();
        send(lit(8'h80, 0), 0);
        #2 rst = 1'b1;
        #1;
        chk("r2_val", bs_val_o, 0);
        chk("r2_rdy", tok_rdy_o, 0);
        chk("r2_busy", busy_o, 0);
        chk("r2_cnt", tok_cnt_o, 0);
        chk("r2_lit", bs_lit_o, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        nval = 0;
        do_start();
        send(lit(8'h90, 0), 0);
        send(pair(7'd5, 7'd12, 1), 1);
        finish(3);
        chk("r_clean_nval", nval, 2);
        chk("r_clean_cnt", tok_cnt_o, 2);
        chk("r_clean_err", err_o, 0);
        n = sb.size();
        chk("sb_drained", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
